// File: rtl/if_fetch_bridge_pkg.sv
// Shared definitions for the instruction-fetch bridge: bus widths, the
// NOP/zero word, FSM state encoding and a word-alignment helper.
// Optional feature macro used by the bridge: IF_HOLD_CACHE_EN.
package if_fetch_bridge_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  // Instruction fetches must be word aligned; only the low two bits matter.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_bridge_timeout_cnt.sv
// Saturating WAIT-phase cycle counter for the fetch bridge. 'expired' is
// raised during the LIMIT-th enabled cycle, so the owner can abort on the
// same edge that would otherwise start cycle LIMIT+1.
module if_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] MAX  = CW'(LIMIT);

  logic [CW-1:0] cnt_reg;

  // Count enabled cycles, restart on clear, stop at LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = enable && (cnt_reg == LAST);

endmodule

// File: rtl/if_fetch_bridge.sv
// Instruction-fetch bridge: turns the core's single-cycle ROM-style fetch
// port into request/grant/rvalid bus reads, holding the last fetched word
// (or an error NOP) in a one-entry buffer that the core hits on.
// Optional feature: IF_HOLD_CACHE_EN keeps the held word valid across
// repeated hits; without it, each hit consumes the entry.
module if_fetch_bridge
  import if_fetch_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  output logic [INST_W-1:0]      rom_data_o,
  output logic                   stallreq_from_if_o,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [INST_W-1:0]      mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   fetch_err_o
);

`ifdef IF_HOLD_CACHE_EN
  localparam bit HOLD_CACHE = 1'b1;
`else
  localparam bit HOLD_CACHE = 1'b0;
`endif

  fetch_state_t           state_reg;
  fetch_state_t           state_next;
  logic [INST_ADDR_W-1:0] areg_reg;
  logic [INST_W-1:0]      dreg_reg;
  logic                   dvalid_reg;
  logic [INST_ADDR_W-1:0] mem_addr_reg;
  logic                   fetch_err_reg;

  logic hit;
  logic start_fetch;
  logic misaligned_miss;
  logic fetch_done_ok;
  logic fetch_done_bad;
  logic timeout_expired;

  assign hit = rom_ce_i && dvalid_reg && (areg_reg == rom_addr_i);

  // New work is only accepted from IDLE; a misaligned miss is answered
  // locally with an error NOP and never reaches the bus.
  assign start_fetch     = (state_reg == ST_IDLE) && rom_ce_i && !hit &&
                           is_word_aligned(rom_addr_i[1:0]);
  assign misaligned_miss = (state_reg == ST_IDLE) && rom_ce_i && !hit &&
                           !is_word_aligned(rom_addr_i[1:0]);
  assign fetch_done_ok   = (state_reg == ST_WAIT) && mem_rvalid_i && !mem_err_i;
  assign fetch_done_bad  = (state_reg == ST_WAIT) &&
                           ((mem_rvalid_i && mem_err_i) ||
                            (!mem_rvalid_i && timeout_expired));

  assign rom_data_o         = hit ? dreg_reg : ZERO_WORD;
  assign stallreq_from_if_o = rom_ce_i && !hit;
  assign mem_addr_o         = mem_addr_reg;
  assign fetch_err_o        = fetch_err_reg;

  if_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_fetch),
    .enable  (state_reg == ST_WAIT),
    .expired (timeout_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_fetch) state_next = ST_REQ;
      ST_REQ:  if (mem_gnt_i) state_next = ST_WAIT;
      ST_WAIT: if (mem_rvalid_i || timeout_expired) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: the request is held for the whole REQ phase.
  always_comb begin
    mem_req_o = 1'b0;
    if (state_reg == ST_REQ) begin
      mem_req_o = 1'b1;
    end
  end

  // Holding buffer, bus address and error pulse. A completing fetch always
  // lands under the address it was issued for, even if the core has moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg_reg      <= '0;
      dreg_reg      <= ZERO_WORD;
      dvalid_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      fetch_err_reg <= 1'b0;
    end else begin
      fetch_err_reg <= misaligned_miss || fetch_done_bad;
      if (start_fetch) begin
        mem_addr_reg <= rom_addr_i;
      end
      if (fetch_done_ok) begin
        dreg_reg   <= mem_rdata_i;
        areg_reg   <= mem_addr_reg;
        dvalid_reg <= 1'b1;
      end else if (fetch_done_bad) begin
        dreg_reg   <= ZERO_WORD;
        areg_reg   <= mem_addr_reg;
        dvalid_reg <= 1'b1;
      end else if (misaligned_miss) begin
        dreg_reg   <= ZERO_WORD;
        areg_reg   <= rom_addr_i;
        dvalid_reg <= 1'b1;
      end else if (!HOLD_CACHE && hit) begin
        dvalid_reg <= 1'b0;
      end
    end
  end

endmodule
